serial_adder: RTL and testbench
===============================

# serial_adder

- Multi-cycle, parametrised successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock through one DIGIT-bit adder slice and a registered carry.
- Start/busy/done handshake; registered sum, carry-out and signed overflow.
- Sits in the basic arithmetic library as the area-minimal adder for datapaths that can tolerate multi-cycle latency.

## Interface

Parameters:
- WIDTH, 8, operand/result width; WIDTH >= 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0. N = WIDTH/DIGIT = digit cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready (state IDLE or DONE).
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in, captured on an accepted start.
- sub  input  1  subtract select, captured on an accepted start. Present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout/ovf updated in the same cycle.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation

FSM states are IDLE, RUN and DONE.

- **IDLE**
  - start=1: load a/b into shift registers, carry FF <= cin, digit counter <= 0, go to RUN.
  - Otherwise hold.
- **RUN**
  - Each cycle adds the low DIGIT bits of both shift registers plus the carry FF.
  - The DIGIT-bit result is shifted into the working register from the MSB side; the carry FF is updated; both operand registers shift right by DIGIT.
  - The counter increments.
  - On the Nth digit, go to DONE and load sum <= working result, cout <= final carry, ovf <= carry-into-MSB XOR final carry.
  - start is ignored in RUN.
- **DONE**
  - done=1 for this cycle only.
  - start=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- **Output stability**
  - sum/cout/ovf change only on the DONE-entry edge and hold until the next completion.
  - The working register is internal, so sum never shows partial results.
- **Arithmetic**
  - Unsigned modulo 2^WIDTH; cout is the true carry.
  - ovf is meaningful for two's-complement operands.

## Timing

- **Start to result**
  - Start accepted on edge 0; busy=1 after edge 0.
  - Digits are processed on edges 1..N.
  - After edge N: busy=0, done=1, results valid.
- **Throughput**
  - Latency is N cycles from accepting edge to done.
  - Back-to-back throughput is one operation per N+1 cycles.
- **Reset**
  - State IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal registers 0.
- **Reset mid-operation**
  - Aborts immediately; no done pulse.
  - Previous sum/cout/ovf are cleared to 0.
- **Edge cases**
  - DIGIT == WIDTH: N=1, one RUN cycle.
  - Input changes on a/b/cin/sub after acceptance have no effect.

## Configuration

- Macro: SERIAL_ADDER_SUB_EN.
- **Defined**
  - Port sub exists and is captured at start.
  - sub=1: operand B is captured inverted and the initial carry FF = 1 (cin ignored), computing a - b.
  - cout=1 means no borrow; ovf is signed subtraction overflow.
  - sub=0 behaves as the add path.
- **Undefined**
  - No sub port; add only; initial carry FF = cin.

## Test plan

- **Unsigned wrap**
  - Stimulus: WIDTH=8, DIGIT=1; a=8'hFF, b=8'h01, cin=0, start for one cycle.
  - Required: busy for 8 cycles; done pulses once after edge 8; sum=8'h00, cout=1, ovf=0.
- **Signed overflow**
  - Stimulus: a=8'h7F, b=8'h01, cin=0.
  - Required: sum=8'h80, cout=0, ovf=1. With a=8'h80, b=8'h80: sum=8'h00, cout=1, ovf=1.
- **Wide digit**
  - Stimulus: WIDTH=8, DIGIT=4; a=8'hA5, b=8'h5A, cin=1.
  - Required: done after edge 2; sum=8'h00, cout=1, ovf=0.
  - Also: start held during RUN starts no extra operation.
- **Back-to-back**
  - Stimulus: start asserted during the DONE cycle with a=8'h03, b=8'h04.
  - Required: accepted with no IDLE gap; next done exactly N+1 cycles after the previous done; sum=8'h07.
  - The prior result holds on sum until then.
- **Reset mid-operation**
  - Stimulus: rst_n low at digit 4 of an 8-digit operation.
  - Required: busy, done, sum, cout and ovf all 0 asynchronously; no done pulse follows after release.
- **Subtract** (SERIAL_ADDER_SUB_EN defined)
  - Stimulus: a=8'h05, b=8'h07, sub=1.
  - Required: sum=8'hFE, cout=0, ovf=0. With a=8'h80, b=8'h01, sub=1: sum=8'h7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds two WIDTH-bit operands plus carry-in,
// DIGIT bits per clock through one DIGIT-bit slice and a registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port (a - b).

// One DIGIT-bit ripple slice; exposes the carry into its top bit so the
// final digit can produce the signed-overflow flag.
module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, work, work_nx;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             accept, last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic [DIGIT-1:0] dsum;
  logic             dco, dcm;

  assign accept = start & ((state == IDLE) | (state == DONE));
  assign last   = (state == RUN) & (cnt == LAST);

  // Operand B / initial carry as loaded; subtract inverts B and forces carry 1
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x   (opa[DIGIT-1:0]),
    .y   (opb[DIGIT-1:0]),
    .ci  (cy),
    .s   (dsum),
    .co  (dco),
    .cmsb(dcm)
  );

  // Working register shifts right; the new digit enters from the MSB side
  always_comb begin
    work_nx = work >> DIGIT;
    work_nx[WIDTH-1 -: DIGIT] = dsum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start is only honoured when ready (IDLE or DONE)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: capture on accept, one digit per RUN cycle, publish on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa  <= '0;
      opb  <= '0;
      work <= '0;
      cnt  <= '0;
      cy   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      opa  <= a;
      opb  <= b_ld;
      work <= '0;
      cnt  <= '0;
      cy   <= c_ld;
    end else if (state == RUN) begin
      opa  <= opa >> DIGIT;
      opb  <= opb >> DIGIT;
      work <= work_nx;
      cnt  <= cnt + CW'(1);
      cy   <= dco;
      if (last) begin
        sum  <= work_nx;
        cout <= dco;
        ovf  <= dcm ^ dco;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a DIGIT=1 (N=8) and a DIGIT=4 (N=2)
// instance, both WIDTH=8. Expected results come from a behavioural adder.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q1[$];
  logic [9:0] q4[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: {ovf, cout, sum}
  function automatic logic [9:0] model(logic [7:0] x, logic [7:0] y, logic c, logic s);
    logic [7:0] yy;
    logic       c0;
    logic [8:0] r;
    logic       v;
    yy = s ? ~y : y;
    c0 = s ? 1'b1 : c;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, c0};
    v  = (x[7] == yy[7]) && (r[7] != x[7]);
    return {v, r[8], r[7:0]};
  endfunction

  function automatic logic get_busy(int inst);
    return (inst == 1) ? busy1 : busy4;
  endfunction
  function automatic logic get_done(int inst);
    return (inst == 1) ? done1 : done4;
  endfunction
  function automatic logic [7:0] get_sum(int inst);
    return (inst == 1) ? sum1 : sum4;
  endfunction

  task automatic set_start(int inst, logic v);
    if (inst == 1) start1 = v;
    else           start4 = v;
  endtask

  // One operation with exact cycle-accurate handshake checks. Called while
  // ready; returns #1 after the done edge (DONE cycle), so a following call
  // exercises back-to-back acceptance.
  task automatic run_op(int inst, logic [7:0] aa, logic [7:0] bb, logic ci, logic sb, bit hold);
    int n;
    logic [7:0] held;
    n    = (inst == 1) ? 8 : 2;
    held = get_sum(inst);
    a = aa; b = bb; cin = ci; sub = sb;
    if (inst == 1) q1.push_back(model(aa, bb, ci, sb));
    else           q4.push_back(model(aa, bb, ci, sb));
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(inst, 1'b0);
    chk("busy_after_accept", get_busy(inst), 1);
    chk("sum_hold_accept", get_sum(inst), held);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = ~sb;
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      if (hold && k == 1) set_start(inst, 1'b0);
      chk("busy_run", get_busy(inst), 1);
      chk("done_early", get_done(inst), 0);
      chk("sum_hold_run", get_sum(inst), held);
    end
    @(posedge clk); #1;
    chk("done_at_n", get_done(inst), 1);
    chk("busy_at_done", get_busy(inst), 0);
  endtask

  task automatic idle_chk(int inst);
    @(posedge clk); #1;
    chk("done_single_pulse", get_done(inst), 0);
    chk("idle_not_busy", get_busy(inst), 0);
  endtask

  // Scoreboard: compare on every done pulse
  always @(negedge clk) begin
    logic [9:0] e;
    if (done1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", done1, 0);
      else begin e = q1.pop_front(); chk("u1_result", {ovf1, cout1, sum1}, e); end
    end
    if (done4) begin
      if (q4.size() == 0) chk("u4_unexpected_done", done4, 0);
      else begin e = q4.pop_front(); chk("u4_result", {ovf4, cout4, sum4}, e); end
    end
  end

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u1", {busy1, done1, ovf1, cout1, sum1}, 0);
    chk("rst_u4", {busy4, done4, ovf4, cout4, sum4}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned wrap, then signed overflows
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 0); idle_chk(1);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0); idle_chk(1);
    run_op(1, 8'h80, 8'h80, 1'b0, 1'b0, 0); idle_chk(1);

    // Wide digit with start held into RUN: exactly one operation
    run_op(4, 8'hA5, 8'h5A, 1'b1, 1'b0, 1); idle_chk(4);
    idle_chk(4);

    // Back-to-back on both instances
    run_op(4, 8'h10, 8'h20, 1'b0, 1'b0, 0);
    run_op(4, 8'h03, 8'h04, 1'b0, 1'b0, 0); idle_chk(4);
    run_op(1, 8'h55, 8'h22, 1'b1, 1'b0, 0);
    run_op(1, 8'h03, 8'h04, 1'b0, 1'b0, 0); idle_chk(1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 0); idle_chk(1);
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 0); idle_chk(1);
    run_op(4, 8'h80, 8'h01, 1'b1, 1'b1, 0); idle_chk(4);
`endif

    // Random mix; operands scrambled after acceptance inside run_op
    for (int i = 0; i < 8; i++) begin
      int inst;
      logic sb;
      inst = (i % 2 == 0) ? 1 : 4;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run_op(inst, 8'($urandom), 8'($urandom), 1'($urandom), sb, 0);
      idle_chk(inst);
    end

    // Reset mid-operation: previous result is 7F+01 style nonzero
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0); idle_chk(1);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_u1", {busy1, done1, ovf1, cout1, sum1}, 0);
    chk("midrst_u4", {busy4, done4, ovf4, cout4, sum4}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_idle", {busy1, done1, sum1}, 0);

    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
